// File: rtl/deferred_step_gen.sv
// Batches per-cycle commit counts into step pulses for the host nstep call and
// walks RUN -> DRAIN -> DONE once the host reports a terminal simv_result.
module deferred_step_gen #(
  parameter int STEP_WIDTH   = 8,
  parameter int INC_WIDTH    = 4,
  parameter int THRESHOLD    = 64,
  parameter int FLUSH_IDLE   = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  commit_valid,
  input  logic [INC_WIDTH-1:0]  commit_cnt,
  input  logic [7:0]            simv_result,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  halt,
  output logic                  finish,
  output logic [7:0]            result
);

  localparam int ACC_W   = STEP_WIDTH + 1;
  localparam int IDLE_W  = $clog2(FLUSH_IDLE + 1);
  localparam int QUIET_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [ACC_W-1:0]   STEP_MAX_A = {1'b0, {STEP_WIDTH{1'b1}}};
  localparam logic [ACC_W-1:0]   THRESH_A   = ACC_W'(THRESHOLD);
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(FLUSH_IDLE);
  localparam logic [QUIET_W-1:0] QUIET_MAX  = QUIET_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [QUIET_W-1:0]    quiet_q, quiet_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halt_q, halt_d;
  logic                  finish_q, finish_d;
  logic [7:0]            result_q, result_d;

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] emit;
  logic             flushReq;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      acc_q    <= '0;
      idle_q   <= '0;
      quiet_q  <= '0;
      step_q   <= '0;
      halt_q   <= 1'b0;
      finish_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idle_q   <= idle_d;
      quiet_q  <= quiet_d;
      step_q   <= step_d;
      halt_q   <= halt_d;
      finish_q <= finish_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    inc      = '0;
    emit     = '0;
    flushReq = 1'b0;
    state_d  = state_q;
    acc_d    = acc_q;
    idle_d   = idle_q;
    quiet_d  = quiet_q;
    step_d   = '0;
    halt_d   = halt_q;
    finish_d = finish_q;
    result_d = result_q;

    // DONE freezes the accumulator: no commits are taken and nothing is emitted.
    if (state_q != DONE) begin
      if (commit_valid) begin
        inc = ACC_W'(commit_cnt);
      end
      flushReq = (acc_q >= THRESH_A) ||
                 ((acc_q != '0) && (idle_q == IDLE_MAX)) ||
                 ((acc_q != '0) && (state_q == DRAIN));
      if (flushReq) begin
        emit = (acc_q > STEP_MAX_A) ? STEP_MAX_A : acc_q;
      end
      acc_d  = acc_q - emit + inc;
      step_d = emit[STEP_WIDTH-1:0];
      if ((commit_valid && (commit_cnt != '0)) || (emit != '0)) begin
        idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    case (state_q)
      RUN: begin
        if (simv_result != 8'd0) begin
          result_d = simv_result;
          halt_d   = 1'b1;
          quiet_d  = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        // Only a cycle with nothing arriving and nothing held counts as quiet.
        if ((inc == '0) && (acc_q == '0)) begin
          quiet_d = quiet_q + QUIET_W'(1);
          if (quiet_d == QUIET_MAX) begin
            state_d  = DONE;
            finish_d = 1'b1;
          end
        end else begin
          quiet_d = '0;
        end
      end
      DONE: begin
        halt_d   = 1'b1;
        finish_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign step   = step_q;
  assign halt   = halt_q;
  assign finish = finish_q;
  assign result = result_q;

endmodule

// File: tb/tb_deferred_step_gen.sv
// Directed bench for deferred_step_gen: threshold batching, saturation with
// carry, idle flush, drain/finish sequencing, DONE stickiness and mid-drain reset.
module tb_deferred_step_gen;

  logic       clock;
  logic       reset;
  logic       commitValid;
  logic [3:0] commitCnt;
  logic [7:0] simvResult;
  logic [7:0] step;
  logic       halt;
  logic       finish;
  logic [7:0] result;

  logic       commitValid2;
  logic [3:0] commitCnt2;
  logic [7:0] simvResult2;
  logic [7:0] step2;
  logic       halt2;
  logic       finish2;
  logic [7:0] result2;

  int checkCount;
  int passCount;

  deferred_step_gen #(
    .STEP_WIDTH(8), .INC_WIDTH(4), .THRESHOLD(64), .FLUSH_IDLE(16), .DRAIN_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .commit_valid(commitValid), .commit_cnt(commitCnt),
    .simv_result(simvResult), .step(step), .halt(halt), .finish(finish), .result(result)
  );

  // Second instance exercises the saturating THRESHOLD=255 configuration.
  deferred_step_gen #(
    .STEP_WIDTH(8), .INC_WIDTH(4), .THRESHOLD(255), .FLUSH_IDLE(16), .DRAIN_CYCLES(8)
  ) dutSat (
    .clock(clock), .reset(reset), .commit_valid(commitValid2), .commit_cnt(commitCnt2),
    .simv_result(simvResult2), .step(step2), .halt(halt2), .finish(finish2), .result(result2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    commitValid  = 1'b0;
    commitCnt    = 4'd0;
    simvResult   = 8'd0;
    commitValid2 = 1'b0;
    commitCnt2   = 4'd0;
    simvResult2  = 8'd0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    commitValid = 1'b1;
    commitCnt   = 4'd15;
    simvResult  = 8'h7F;
    tick();
    tick();
    checkCount++;
    if ({step, halt, finish, result} !== 18'd0)
      $display("[TB] FAIL reset_outputs: got step=%0d halt=%0b finish=%0b result=%0h, want all 0",
               step, halt, finish, result);
    else passCount++;
    idleInputs();
    reset = 1'b0;
    tick();
    checkCount++;
    if ({step, halt, finish, result} !== 18'd0)
      $display("[TB] FAIL reset_release: got step=%0d halt=%0b finish=%0b result=%0h, want all 0",
               step, halt, finish, result);
    else passCount++;
  endtask

  task automatic test_threshold();
    logic [7:0] expStep;
    doReset();
    for (int k = 1; k <= 40; k++) begin
      commitValid = (k <= 16);
      commitCnt   = (k <= 16) ? 4'd4 : 4'd0;
      tick();
      expStep = (k == 17) ? 8'd64 : 8'd0;
      checkCount++;
      if (step !== expStep)
        $display("[TB] FAIL threshold_step k=%0d: got %0d, want %0d", k, step, expStep);
      else passCount++;
    end
  endtask

  task automatic test_saturate();
    logic [7:0] expStep;
    int         stepSum;
    stepSum = 0;
    doReset();
    for (int k = 1; k <= 125; k++) begin
      commitValid2 = (k <= 100);
      commitCnt2   = (k <= 100) ? 4'd15 : 4'd0;
      tick();
      if (k >= 18 && k <= 86 && ((k - 18) % 17) == 0) expStep = 8'd255;
      else if (k == 117) expStep = 8'd225;
      else expStep = 8'd0;
      stepSum += int'(step2);
      checkCount++;
      if (step2 !== expStep)
        $display("[TB] FAIL saturate_step k=%0d: got %0d, want %0d", k, step2, expStep);
      else passCount++;
    end
    checkCount++;
    if (stepSum !== 1500)
      $display("[TB] FAIL saturate_conservation: step sum %0d, want 1500", stepSum);
    else passCount++;
  endtask

  task automatic test_idle_flush();
    logic [7:0] expStep;
    doReset();
    for (int k = 1; k <= 40; k++) begin
      if (k <= 3) begin
        commitValid = 1'b1;
        commitCnt   = 4'd1;
      end else if (k % 2 == 1) begin
        commitValid = 1'b1;
        commitCnt   = 4'd0;
      end else begin
        commitValid = 1'b0;
        commitCnt   = 4'd9;
      end
      tick();
      expStep = (k == 20) ? 8'd3 : 8'd0;
      checkCount++;
      if (step !== expStep)
        $display("[TB] FAIL idle_flush_step k=%0d: got %0d, want %0d", k, step, expStep);
      else passCount++;
    end
  endtask

  task automatic test_drain();
    doReset();
    commitValid = 1'b1;
    commitCnt   = 4'd5;
    tick();
    tick();
    commitValid = 1'b0;
    commitCnt   = 4'd0;
    simvResult  = 8'h2A;
    tick();
    checkCount++;
    if (halt !== 1'b1 || result !== 8'h2A || finish !== 1'b0 || step !== 8'd0)
      $display("[TB] FAIL drain_entry: got halt=%0b result=%0h finish=%0b step=%0d, want 1/2a/0/0",
               halt, result, finish, step);
    else passCount++;
    commitValid = 1'b1;
    commitCnt   = 4'd1;
    tick();
    checkCount++;
    if (step !== 8'd10) $display("[TB] FAIL drain_step0: got %0d, want 10", step);
    else passCount++;
    tick();
    checkCount++;
    if (step !== 8'd1) $display("[TB] FAIL drain_step1: got %0d, want 1", step);
    else passCount++;
    commitValid = 1'b0;
    commitCnt   = 4'd0;
    tick();
    checkCount++;
    if (step !== 8'd1) $display("[TB] FAIL drain_step2: got %0d, want 1", step);
    else passCount++;
    for (int k = 7; k <= 14; k++) begin
      tick();
      checkCount++;
      if (finish !== (k == 14) || step !== 8'd0 || halt !== 1'b1)
        $display("[TB] FAIL drain_quiet k=%0d: got finish=%0b step=%0d halt=%0b, want finish=%0b step=0 halt=1",
                 k, finish, step, halt, (k == 14));
      else passCount++;
    end
  endtask

  task automatic test_done();
    simvResult  = 8'h05;
    commitValid = 1'b1;
    commitCnt   = 4'd3;
    for (int k = 0; k < 25; k++) begin
      tick();
      checkCount++;
      if (result !== 8'h2A || step !== 8'd0 || finish !== 1'b1 || halt !== 1'b1)
        $display("[TB] FAIL done_sticky k=%0d: got result=%0h step=%0d finish=%0b halt=%0b, want 2a/0/1/1",
                 k, result, step, finish, halt);
      else passCount++;
    end
    idleInputs();
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] expStep;
    doReset();
    commitValid = 1'b1;
    commitCnt   = 4'd5;
    tick();
    tick();
    commitValid = 1'b0;
    commitCnt   = 4'd0;
    simvResult  = 8'h33;
    tick();
    commitValid = 1'b1;
    commitCnt   = 4'd7;
    tick();
    checkCount++;
    if (step !== 8'd10 || halt !== 1'b1)
      $display("[TB] FAIL middrain_pre: got step=%0d halt=%0b, want 10/1", step, halt);
    else passCount++;
    idleInputs();
    reset = 1'b1;
    tick();
    checkCount++;
    if ({step, halt, finish, result} !== 18'd0)
      $display("[TB] FAIL middrain_reset: got step=%0d halt=%0b finish=%0b result=%0h, want all 0",
               step, halt, finish, result);
    else passCount++;
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      commitValid = (k <= 16);
      commitCnt   = (k <= 16) ? 4'd4 : 4'd0;
      tick();
      expStep = (k == 17) ? 8'd64 : 8'd0;
      checkCount++;
      if (step !== expStep || halt !== 1'b0 || result !== 8'd0)
        $display("[TB] FAIL middrain_restart k=%0d: got step=%0d halt=%0b result=%0h, want step=%0d halt=0 result=0",
                 k, step, halt, result, expStep);
      else passCount++;
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    idleInputs();
    test_reset();
    test_threshold();
    test_saturate();
    test_idle_flush();
    test_drain();
    test_done();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/deferred_step_gen.md
# deferred_step_gen

Producer-side companion to the deferred-result controller: accumulates per-cycle commit counts from the difftest pipeline into batched `step` values for the host `nstep` call, and consumes the host-supplied deferred `simv_result` to halt the DUT cleanly and raise `finish`. It sits between the commit-count aggregation logic and the deferred controller, driving its `step` input and reading its `simv_result` output.

## Interface
- `STEP_WIDTH`, default 8: width of `step`; `STEP_MAX` = 2^STEP_WIDTH − 1.
- `INC_WIDTH`, default 4: width of `commit_cnt`; must be < STEP_WIDTH.
- `THRESHOLD`, default 64: emit a step once the accumulated count is ≥ THRESHOLD; range 1..STEP_MAX.
- `FLUSH_IDLE`, default 16: emit a partial step after this many consecutive cycles without a commit; must be ≥ 1.
- `DRAIN_CYCLES`, default 8: number of quiet cycles in DRAIN before entering DONE; must be ≥ 1.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `commit_valid`  in  1: `commit_cnt` is valid this cycle.
- `commit_cnt`  in  INC_WIDTH: number of instructions committed this cycle.
- `simv_result`  in  8: deferred host result; 0 means running, nonzero means a terminal code. Sampled as a level.
- `step`  out  STEP_WIDTH: registered; nonzero for exactly one cycle per emission, 0 otherwise.
- `halt`  out  1: registered; requests the DUT to stop committing.
- `finish`  out  1: registered; simulation-complete indication.
- `result`  out  8: registered; latched terminal code.

## Operation
- Accumulator `acc` is STEP_WIDTH+1 bits wide. `inc` = `commit_cnt` when `commit_valid`, else 0.
- Emission amount `emit` is computed from the registered `acc`:
  - `emit` = min(acc, STEP_MAX) when any of these holds:
    - acc ≥ THRESHOLD;
    - acc ≠ 0 and `idle_cnt` = FLUSH_IDLE;
    - acc ≠ 0 and state = DRAIN.
  - Otherwise `emit` = 0.
- Each edge: `acc` ← acc − emit + inc, and `step` ← emit.
  - With INC_WIDTH < STEP_WIDTH, `acc` never overflows. A saturated emission leaves the remainder in `acc`.
- `idle_cnt`:
  - Cleared on any cycle with `commit_valid`=1 and `commit_cnt`≠0, and on any emission.
  - Otherwise increments, saturating at FLUSH_IDLE.
- A `commit_valid` with `commit_cnt`=0 counts as idle.
- State machine, reset state RUN:
  - RUN: `halt`=0. When `simv_result` ≠ 0: latch `result` ← simv_result, set `halt` ← 1, go to DRAIN.
  - DRAIN: commits are still accepted (in-flight retirement) and the accumulator flushes every cycle. A quiet counter counts cycles with `inc`=0 and `acc`=0, and clears otherwise. When it reaches DRAIN_CYCLES, go to DONE.
  - DONE: `finish`=1, `halt`=1, `step`=0. Commits are ignored and `acc` is held. `simv_result` is ignored. DONE is left only by `reset`.
- `result` is latched once; later changes of `simv_result` have no effect until reset.

## Timing
- Reset values (asserted during and after reset): `step`=0, `halt`=0, `finish`=0, `result`=0; internally `acc`=0, `idle_cnt`=0, quiet counter=0, state=RUN.
- Reset is honoured in every state, including mid-DRAIN; pending `acc` is discarded.
- Commit-to-step latency:
  - A commit in cycle t enters `acc` at the end of t.
  - The earliest `step` carrying it is visible in cycle t+2.
- A commit arriving in the same cycle as an emission is added to the remainder and is never lost or double-counted.
- `simv_result` going nonzero in cycle t gives `halt`=1 and `result` valid in t+1, and state DRAIN from t+1.
- `finish` rises DRAIN_CYCLES + 1 cycles after the last cycle in which `acc` or `inc` was nonzero, counted from DRAIN entry at the earliest.
- Conservation invariant: the sum of all `step` values, plus `acc`, equals the sum of accepted `inc` since reset (checked in RUN and DRAIN).

## Test plan
- Default parameters, `commit_cnt`=4 every cycle for 16 cycles → a single `step`=64 pulse in cycle 17, then `acc`=0.
- `commit_cnt`=15 every cycle with THRESHOLD=255 → `step`=255 pulses; the remainder is carried; the conservation invariant holds after 100 cycles.
- 3 commits of 1 each, then idle → after 16 idle cycles a `step`=3 pulse, then `step` stays 0.
- `simv_result`=0x2A while `acc`=10, with 2 more cycles of `commit_cnt`=1:
  - next cycle: `halt`=1 and `result`=0x2A;
  - then `step` pulses of 10, 1, 1;
  - then `finish`=1 after 8 quiet cycles.
- In DONE, drive `simv_result`=0x05 and commits → `result` stays 0x2A, `step` stays 0, `finish` stays 1.
- Assert `reset` in the middle of DRAIN → next cycle all outputs are 0, state is RUN, and accumulation restarts from 0.
